// File: rtl/gf2mz_loader.sv
// Operand loader and run sequencer for a gf2mz multiplier core: streams n words
// into the A memory, then n into B, kicks the core and times its run.
//
// state   | meaning
// IDLE    | waiting for go
// LOAD_A  | accepting operand-A beats, writing A memory
// LOAD_B  | accepting operand-B beats, writing B memory
// START   | one-cycle core_start pulse, runtime counter cleared
// WAIT    | counting cycles until core_done
// FIN     | one-cycle run_done pulse
module gf2mz_loader #(
  parameter int n  = 83,
  parameter int m  = 67,
  parameter int AW = $clog2(n)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          go,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [m-1:0]  in_data,
  output logic          we_a,
  output logic          we_b,
  output logic [AW-1:0] waddr,
  output logic [m-1:0]  wdata,
  output logic          core_start,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  output logic [31:0]   cycles
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(n - 1);

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic          we_a_q;
  logic          we_b_q;
  logic [AW-1:0] waddr_q;
  logic [m-1:0]  wdata_q;
  logic          core_start_q;
  logic          run_done_q;
  logic [31:0]   cycles_q;

  logic          accept;
  logic          last_beat;

  assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      we_a_q       <= 1'b0;
      we_b_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      core_start_q <= 1'b0;
      run_done_q   <= 1'b0;
      cycles_q     <= '0;
    end else begin
      we_a_q       <= 1'b0;
      we_b_q       <= 1'b0;
      core_start_q <= 1'b0;
      run_done_q   <= 1'b0;

      // Writes trail the accepted beat by one cycle, so the last B write
      // lands in the START cycle alongside core_start.
      if (accept) begin
        waddr_q <= idx_q;
        wdata_q <= in_data;
        we_a_q  <= (state_q == S_LOAD_A);
        we_b_q  <= (state_q == S_LOAD_B);
        idx_q   <= last_beat ? '0 : idx_q + AW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (go) state_q <= S_LOAD_A;
        end
        S_LOAD_A: begin
          if (accept && last_beat) state_q <= S_LOAD_B;
        end
        S_LOAD_B: begin
          if (accept && last_beat) begin
            state_q      <= S_START;
            core_start_q <= 1'b1;
          end
        end
        S_START: begin
          cycles_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            state_q    <= S_FIN;
            run_done_q <= 1'b1;
          end else if (cycles_q != '1) begin
            cycles_q <= cycles_q + 32'd1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign we_a       = we_a_q;
  assign we_b       = we_b_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign core_start = core_start_q;
  assign run_done   = run_done_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_gf2mz_loader.sv
// Directed bench for gf2mz_loader with n=4, m=8: load sequencing, runtime
// counting, stalls, ignored go/core_done, and asynchronous reset.
module tb_gf2mz_loader;

  localparam int N  = 4;
  localparam int M  = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          go;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_data;
  logic          we_a;
  logic          we_b;
  logic [AW-1:0] waddr;
  logic [M-1:0]  wdata;
  logic          core_start;
  logic          core_done;
  logic          busy;
  logic          run_done;
  logic [31:0]   cycles;

  int passed = 0;
  int total  = 0;

  gf2mz_loader #(.n(N), .m(M), .AW(AW)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .go         (go),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .we_a       (we_a),
    .we_b       (we_b),
    .waddr      (waddr),
    .wdata      (wdata),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .run_done   (run_done),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic ea, input logic eb,
                        input logic [AW-1:0] ad, input logic [M-1:0] dt);
    chk({tag, ".we_a"}, {31'd0, we_a}, {31'd0, ea});
    chk({tag, ".we_b"}, {31'd0, we_b}, {31'd0, eb});
    if (ea || eb) begin
      chk({tag, ".waddr"}, {30'd0, waddr}, {30'd0, ad});
      chk({tag, ".wdata"}, {24'd0, wdata}, {24'd0, dt});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".we_a"},       {31'd0, we_a},       32'd0);
    chk({tag, ".we_b"},       {31'd0, we_b},       32'd0);
    chk({tag, ".waddr"},      {30'd0, waddr},      32'd0);
    chk({tag, ".wdata"},      {24'd0, wdata},      32'd0);
    chk({tag, ".core_start"}, {31'd0, core_start}, 32'd0);
    chk({tag, ".run_done"},   {31'd0, run_done},   32'd0);
    chk({tag, ".cycles"},     cycles,              32'd0);
    chk({tag, ".busy"},       {31'd0, busy},       32'd0);
    chk({tag, ".in_ready"},   {31'd0, in_ready},   32'd0);
  endtask

  initial begin
    int run_pulses;
    rst_b = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; core_done = 1'b0;
    #1;
    chk_all_zero("reset");
    step(); step();
    rst_b = 1'b1;
    step();
    chk("idle.busy", {31'd0, busy}, 32'd0);

    // Sequence 1: back-to-back beats 0x11..0x18, core done after 5 counted cycles
    go = 1'b1;
    step();
    go = 1'b0;
    chk("s1.busy_load", {31'd0, busy}, 32'd1);
    chk("s1.ready_load", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h11 + 8'(i);
      step();
      chk_wr($sformatf("s1.beat%0d", i), i < 4, i >= 4, AW'(i % 4), 8'h11 + 8'(i));
      chk($sformatf("s1.busy%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("s1.start%0d", i), {31'd0, core_start}, {31'd0, i == 7});
    end
    in_valid = 1'b0;
    chk("s1.ready_start", {31'd0, in_ready}, 32'd0);
    step();
    chk("s1.start_once", {31'd0, core_start}, 32'd0);
    chk("s1.wait_cleared", cycles, 32'd0);
    run_pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("s1.wait%0d", i), cycles, 32'(i));
      if (run_done) run_pulses++;
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("s1.fin_run_done", {31'd0, run_done}, 32'd1);
    chk("s1.fin_cycles", cycles, 32'd5);
    chk("s1.fin_busy", {31'd0, busy}, 32'd1);
    step();
    if (run_done) run_pulses++;
    chk("s1.run_pulses_extra", 32'(run_pulses), 32'd0);
    chk("s1.idle_busy", {31'd0, busy}, 32'd0);
    chk("s1.idle_ready", {31'd0, in_ready}, 32'd0);
    chk("s1.idle_cycles_hold", cycles, 32'd5);

    // Sequence 2: core_done high before go and through START
    core_done = 1'b1;
    step();
    chk("s2.idle_ignores_done", {31'd0, busy}, 32'd0);
    go = 1'b1;
    step();
    go = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h31 + 8'(i);
      step();
      chk_wr($sformatf("s2.beat%0d", i), i < 4, i >= 4, AW'(i % 4), 8'h31 + 8'(i));
    end
    in_valid = 1'b0;
    chk("s2.start", {31'd0, core_start}, 32'd1);
    step();
    chk("s2.wait_not_fin", {31'd0, run_done}, 32'd0);
    chk("s2.wait_busy", {31'd0, busy}, 32'd1);
    chk("s2.wait_cycles", cycles, 32'd0);
    step();
    chk("s2.fin_run_done", {31'd0, run_done}, 32'd1);
    chk("s2.fin_cycles", cycles, 32'd0);
    core_done = 1'b0;
    step();
    chk("s2.idle_busy", {31'd0, busy}, 32'd0);

    // Sequence 3: stalls in LOAD_A, stray go/core_done in LOAD_B
    go = 1'b1;
    step();
    go = 1'b0;
    in_valid = 1'b1; in_data = 8'h21;
    step();
    chk_wr("s3.a0", 1'b1, 1'b0, 2'd0, 8'h21);
    in_valid = 1'b0; in_data = 8'h22;
    step();
    chk_wr("s3.gap0", 1'b0, 1'b0, 2'd0, 8'h00);
    in_valid = 1'b1; in_data = 8'h23;
    step();
    chk_wr("s3.a1", 1'b1, 1'b0, 2'd1, 8'h23);
    in_valid = 1'b0; in_data = 8'h24;
    step();
    chk_wr("s3.gap1", 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    chk_wr("s3.gap2", 1'b0, 1'b0, 2'd0, 8'h00);
    in_valid = 1'b1; in_data = 8'h25;
    step();
    chk_wr("s3.a2", 1'b1, 1'b0, 2'd2, 8'h25);
    in_data = 8'h26;
    step();
    chk_wr("s3.a3", 1'b1, 1'b0, 2'd3, 8'h26);
    go = 1'b1; core_done = 1'b1; in_data = 8'h41;
    step();
    go = 1'b0; core_done = 1'b0;
    chk_wr("s3.b0", 1'b0, 1'b1, 2'd0, 8'h41);
    chk("s3.b0_ready", {31'd0, in_ready}, 32'd1);
    chk("s3.b0_no_start", {31'd0, core_start}, 32'd0);
    chk("s3.b0_no_fin", {31'd0, run_done}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      in_data = 8'h41 + 8'(i);
      step();
      chk_wr($sformatf("s3.b%0d", i), 1'b0, 1'b1, AW'(i), 8'h41 + 8'(i));
    end
    in_valid = 1'b0;
    chk("s3.start", {31'd0, core_start}, 32'd1);
    step();
    step();
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("s3.fin_run_done", {31'd0, run_done}, 32'd1);
    chk("s3.fin_cycles", cycles, 32'd2);
    step();

    // Sequence 4: asynchronous reset after 6 of 8 beats
    go = 1'b1;
    step();
    go = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h51 + 8'(i);
      step();
    end
    chk_wr("s4.pre_reset", 1'b0, 1'b1, 2'd1, 8'h56);
    #2;
    rst_b = 1'b0;
    #1;
    chk_all_zero("s4.reset");
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("s4.post_we_a%0d", i), {31'd0, we_a}, 32'd0);
      chk($sformatf("s4.post_we_b%0d", i), {31'd0, we_b}, 32'd0);
      chk($sformatf("s4.post_start%0d", i), {31'd0, core_start}, 32'd0);
      chk($sformatf("s4.post_ready%0d", i), {31'd0, in_ready}, 32'd0);
    end
    go = 1'b1; in_data = 8'h61;
    step();
    go = 1'b0;
    step();
    chk_wr("s4.restart_a0", 1'b1, 1'b0, 2'd0, 8'h61);
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
